// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two write ports (B wins on collision),
// and a self-clearing sweep that runs after reset and on clr_req.
module regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 0,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*AW-1:0]     ra,
  output logic [NRD*XLEN-1:0]   rd,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic [AW-1:0]         wa_a,
  input  logic [AW-1:0]         wa_b,
  input  logic [XLEN-1:0]       wd_a,
  input  logic [XLEN-1:0]       wd_b,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  zero_wr_err,
  output logic                  state_dbg
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

  state_e            state, state_nxt;
  logic [AW-1:0]     clr_ptr, clr_ptr_nxt;
  logic [XLEN-1:0]   mem [NREGS];
  logic              ready;
  logic              a_zero, b_zero;
  logic              wr_a_ok, wr_b_ok;

  assign ready     = (state == READY);
  assign busy      = ~ready;
  assign state_dbg = state;

  // Writes to register 0 are discarded (and flagged) when it is hardwired to zero.
  assign a_zero  = (ZERO_REG != 0) && (wa_a == '0);
  assign b_zero  = (ZERO_REG != 0) && (wa_b == '0);
  assign wr_a_ok = ready && we_a && !a_zero;
  assign wr_b_ok = ready && we_b && !b_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // clr_req is a one-cycle pulse sampled only in READY; pulses during a sweep are ignored.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + AW'(1);
        if (clr_ptr == AW'(NREGS - 1)) begin
          state_nxt   = READY;
          clr_ptr_nxt = '0;
        end
      end
      READY: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  // Storage has no reset; the sweep is what zeroes it. Port B is written last so it wins.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[clr_ptr] <= '0;
    end else begin
      if (wr_a_ok) mem[wa_a] <= wd_a;
      if (wr_b_ok) mem[wa_b] <= wd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_wr_err <= 1'b0;
    end else if (ready && ((we_a && a_zero) || (we_b && b_zero))) begin
      zero_wr_err <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;

    assign addr = ra[k*AW +: AW];

    always_comb begin
      data = '0;
      if (ready) begin
        if ((ZERO_REG != 0) && (addr == '0)) begin
          data = '0;
        end else if ((BYPASS != 0) && wr_b_ok && (wa_b == addr)) begin
          data = wd_b;
        end else if ((BYPASS != 0) && wr_a_ok && (wa_a == addr)) begin
          data = wd_a;
        end else begin
          data = mem[addr];
        end
      end
    end

    assign rd[k*XLEN +: XLEN] = data;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (hardwired-x0/no-bypass and plain-x0/bypass) share stimulus
// and are checked every cycle against an array-based model, plus literal directed checks.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0]   ra;
  logic                we_a, we_b, clr_req;
  logic [AW-1:0]       wa_a, wa_b;
  logic [XLEN-1:0]     wd_a, wd_b;
  logic [NRD*XLEN-1:0] rd0, rd1;
  logic                busy0, busy1, err0, err1, st0, st1;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd0),
    .we_a(we_a), .we_b(we_b), .wa_a(wa_a), .wa_b(wa_b), .wd_a(wd_a), .wd_b(wd_b),
    .clr_req(clr_req), .busy(busy0), .zero_wr_err(err0), .state_dbg(st0)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(0), .BYPASS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd1),
    .we_a(we_a), .we_b(we_b), .wa_a(wa_a), .wa_b(wa_b), .wd_a(wd_a), .wd_b(wd_b),
    .clr_req(clr_req), .busy(busy1), .zero_wr_err(err1), .state_dbg(st1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Instance 0: x0 hardwired, no bypass. Instance 1: x0 ordinary, bypass on.
  logic [XLEN-1:0] mm [2][NREGS];
  int sweep = 0;
  bit merr [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep = NREGS;
      merr  = '{1'b0, 1'b0};
      for (int i = 0; i < 2; i++) for (int j = 0; j < NREGS; j++) mm[i][j] = '0;
    end else if (sweep > 0) begin
      sweep--;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (we_a && !(i == 0 && wa_a == 0)) mm[i][wa_a] = wd_a;
        if (we_b && !(i == 0 && wa_b == 0)) mm[i][wa_b] = wd_b;
      end
      if ((we_a && wa_a == 0) || (we_b && wa_b == 0)) merr[0] = 1'b1;
      if (clr_req) begin
        sweep = NREGS;
        for (int i = 0; i < 2; i++) for (int j = 0; j < NREGS; j++) mm[i][j] = '0;
      end
    end
  end

  function automatic logic [XLEN-1:0] exp_rd(input int i, input logic [AW-1:0] a);
    if (sweep > 0) return '0;
    if (i == 0 && a == 0) return '0;
    if (i == 1) begin
      if (we_b && wa_b == a) return wd_b;
      if (we_a && wa_a == a) return wd_a;
    end
    return mm[i][a];
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy0", {31'b0, busy0}, {31'b0, sweep > 0});
      chk("busy1", {31'b0, busy1}, {31'b0, sweep > 0});
      chk("state0", {31'b0, st0}, {31'b0, sweep == 0});
      chk("err0", {31'b0, err0}, {31'b0, merr[0]});
      chk("err1", {31'b0, err1}, 32'b0);
      for (int k = 0; k < NRD; k++) begin
        chk($sformatf("rd0_p%0d", k), rd0[k*XLEN +: XLEN], exp_rd(0, ra[k*AW +: AW]));
        chk($sformatf("rd1_p%0d", k), rd1[k*XLEN +: XLEN], exp_rd(1, ra[k*AW +: AW]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_a = 1'b0; we_b = 1'b0; clr_req = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy0 === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    ra = '0; we_a = 0; we_b = 0; wa_a = '0; wa_b = '0; wd_a = '0; wd_b = '0; clr_req = 0;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) tick();
    chk("rst_busy", {31'b0, busy0}, 32'd1);
    chk("rst_err", {31'b0, err0}, 32'd0);
    chk("rst_rd", rd0[31:0], 32'd0);

    rst_n = 1'b1;
    count_busy(n);
    chk("reset_sweep_len", n, 32'd32);
    for (int i = 0; i < NREGS; i++) begin
      ra = {AW'(i), AW'(i)};
      #1;
      chk("post_reset_rd0", rd0[XLEN-1:0], 32'd0);
      chk("post_reset_rd1", rd0[2*XLEN-1:XLEN], 32'd0);
    end
    tick();

    // Dual write, different registers.
    we_a = 1; wa_a = 5; wd_a = 32'hDEADBEEF;
    we_b = 1; wa_b = 7; wd_b = 32'h12345678;
    ra = {5'd7, 5'd5};
    #1;
    chk("nobyp_x5_before", rd0[31:0], 32'd0);
    chk("byp_x5_before", rd1[31:0], 32'hDEADBEEF);
    tick();
    idle();
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h12345678);
    chk("x5_rd0", rd0[31:0], exp_q.pop_front());
    chk("x7_rd1", rd0[63:32], exp_q.pop_front());

    // Same-address collision: B wins.
    we_a = 1; wa_a = 9; wd_a = 32'h1;
    we_b = 1; wa_b = 9; wd_b = 32'h2;
    ra = {5'd9, 5'd9};
    #1;
    chk("byp_x9_same_cycle", rd1[31:0], 32'h2);
    chk("nobyp_x9_same_cycle", rd0[31:0], 32'h0);
    tick();
    idle();
    chk("x9_after", rd0[31:0], 32'h2);
    chk("x9_after_byp", rd1[63:32], 32'h2);

    // Write to x0.
    we_a = 1; wa_a = 0; wd_a = 32'hFFFFFFFF;
    ra = '0;
    #1;
    chk("err_before_edge", {31'b0, err0}, 32'd0);
    tick();
    idle();
    chk("err_set", {31'b0, err0}, 32'd1);
    chk("x0_hardwired", rd0[31:0], 32'd0);
    chk("x0_ordinary", rd1[31:0], 32'hFFFFFFFF);
    repeat (3) tick();
    chk("err_sticky", {31'b0, err0}, 32'd1);

    // Clear sweep; writes and further clr_req during the sweep are dropped.
    we_a = 1; wa_a = 3; wd_a = 32'hAA;
    tick();
    idle();
    ra = {5'd3, 5'd3};
    #1;
    chk("x3_written", rd0[31:0], 32'hAA);
    clr_req = 1;
    tick();
    clr_req = 0;
    chk("clr_busy", {31'b0, busy0}, 32'd1);
    we_a = 1; wa_a = 4; wd_a = 32'h55; clr_req = 1;
    tick();
    idle();
    count_busy(n);
    chk("clr_sweep_len", n + 1, 32'd32);
    ra = {5'd4, 5'd3};
    #1;
    chk("x3_cleared", rd0[31:0], 32'd0);
    chk("x4_dropped", rd0[63:32], 32'd0);
    chk("x4_dropped_byp", rd1[63:32], 32'd0);

    // Reset in the middle of a sweep restarts it.
    rst_n = 0;
    tick();
    rst_n = 1;
    repeat (10) tick();
    chk("mid_sweep_busy", {31'b0, busy0}, 32'd1);
    rst_n = 0;
    tick();
    chk("rst_mid_busy", {31'b0, busy0}, 32'd1);
    chk("rst_mid_err", {31'b0, err0}, 32'd0);
    rst_n = 1;
    count_busy(n);
    chk("restart_sweep_len", n, 32'd32);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      we_a = ($urandom_range(0, 1) == 1);
      we_b = ($urandom_range(0, 2) == 0);
      wa_a = AW'($urandom_range(0, NREGS - 1));
      wa_b = ($urandom_range(0, 3) == 0) ? wa_a : AW'($urandom_range(0, NREGS - 1));
      wd_a = $urandom;
      wd_b = $urandom;
      ra = {AW'($urandom_range(0, NREGS - 1)),
            ($urandom_range(0, 2) == 0) ? wa_a : AW'($urandom_range(0, NREGS - 1))};
      clr_req = ($urandom_range(0, 149) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    idle();
    rst_n = 1;
    tick();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32: data width of every register in bits.
REQ-002 Parameter NREGS, default 32: number of registers; power of two, 2..256; AW = log2(NREGS).
REQ-003 Parameter NRD, default 2: number of combinational read ports, 1..4.
REQ-004 Parameter ZERO_REG, default 1: 1 = register 0 is hardwired to zero; 0 = register 0 is an ordinary register.
REQ-005 Parameter BYPASS, default 0: 1 = write-to-read forwarding in the same cycle; 0 = no forwarding.
REQ-006 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 Port ra, input, NRD*AW bits: read addresses; port k occupies bits [k*AW +: AW].
REQ-009 Port rd, output, NRD*XLEN bits: read data; port k occupies bits [k*XLEN +: XLEN].
REQ-010 Ports we_a / we_b, input, 1 bit each: write enables for write ports A and B.
REQ-011 Ports wa_a / wa_b, input, AW bits each: write addresses for ports A and B.
REQ-012 Ports wd_a / wd_b, input, XLEN bits each: write data for ports A and B.
REQ-013 Port clr_req, input, 1 bit: single-cycle pulse that requests a full clear sweep.
REQ-014 Port busy, output, 1 bit: high while a clear sweep is in progress.
REQ-015 Port zero_wr_err, output, 1 bit: sticky flag; set by any accepted-cycle write to register 0 while ZERO_REG=1.

Function
REQ-016 The controller SHALL have two states: CLEAR and READY.
REQ-017 In CLEAR, a pointer clr_ptr SHALL write zero to register clr_ptr on each clock edge and then increment; when clr_ptr = NREGS-1, the clear SHALL complete and the next state SHALL be READY.
REQ-018 A clear sweep SHALL take exactly NREGS cycles, and busy SHALL be 1 for exactly those cycles.
REQ-019 In READY, a clr_req pulse SHALL enter CLEAR with clr_ptr=0 on the next edge; any writes presented in that same cycle SHALL still be applied before the sweep starts.
REQ-020 clr_req asserted while in CLEAR SHALL be ignored: the sweep is not restarted.
REQ-021 While busy=1, we_a and we_b SHALL be ignored and every rd port SHALL return 0.
REQ-022 In READY, each enabled write port SHALL update its register on the rising edge.
REQ-023 If we_a and we_b are both set and wa_a = wa_b, port B SHALL win and wd_b is stored.
REQ-024 With ZERO_REG=1, writes to address 0 SHALL be discarded and SHALL set zero_wr_err, which stays 1 until reset; reads of address 0 SHALL return 0.
REQ-025 With ZERO_REG=0, address 0 SHALL be an ordinary register and zero_wr_err SHALL stay 0.
REQ-026 Reads SHALL be combinational: rd port k reflects register ra[k] with zero-cycle latency.
REQ-027 With BYPASS=1 in READY, if ra[k] matches an enabled, non-discarded write address, rd[k] SHALL return that write data, with port B taking priority over port A; with BYPASS=0, rd[k] SHALL return the stored value until the clock edge.
REQ-028 Read addresses are always in range (NREGS is a power of two), so no out-of-range handling SHALL exist.

Reset
REQ-029 When rst_n=0, the block SHALL asynchronously force state=CLEAR, clr_ptr=0, busy=1 and zero_wr_err=0, and rd SHALL read 0.
REQ-030 The array contents SHALL NOT be asynchronously reset; they are zeroed by the clear sweep that starts on the first clock edge after rst_n rises.
REQ-031 If rst_n is asserted mid-sweep, the sweep SHALL restart from clr_ptr=0.
REQ-032 After reset release, busy SHALL fall after exactly NREGS edges, and every register SHALL then read 0.

Verification
REQ-033 Reset release with defaults -> busy=1 for 32 cycles, then 0; all 32 registers read 0x00000000 on ports 0 and 1.
REQ-034 In READY: write A x5=0xDEADBEEF and B x7=0x12345678 in the same cycle -> next cycle rd0(ra=5)=0xDEADBEEF and rd1(ra=7)=0x12345678.
REQ-035 we_a and we_b both to x9, wd_a=0x1, wd_b=0x2 -> x9 reads 0x2; with BYPASS=1, rd(ra=9) reads 0x2 in the write cycle itself.
REQ-036 ZERO_REG=1: write x0=0xFFFFFFFF -> x0 reads 0 and zero_wr_err=1 from the next edge until rst_n falls.
REQ-037 clr_req pulse after x3=0xAA is written -> busy=1 for 32 cycles; a write to x4 during busy is dropped; afterwards x3=0 and x4=0.
REQ-038 rst_n pulsed low at sweep cycle 10 -> busy stays 1; the sweep restarts at 0 and busy falls 32 edges after rst_n rises.
